// File: rtl/retro_memory_arbiter.sv
// Round-robin arbiter sharing one memory port among several initiators.
// A tag FIFO records who issued each read, so in-order read data can be returned to the right initiator.
module retro_memory_arbiter #(
    parameter int NumInitiators   = 4,
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1,
    parameter int MaxOutstanding  = 4
) (
    input  logic                                   Clk,
    input  logic                                   ResetN,
    input  logic [NumInitiators*AddressBusWidth-1:0] ReqAddress,
    input  logic [NumInitiators*8*DataBusWidth-1:0]  ReqDout,
    input  logic [NumInitiators*8*DataBusWidth-1:0]  ReqAccess,
    input  logic [NumInitiators-1:0]                 ReqWrite,
    output logic [NumInitiators-1:0]                 ReqReady,
    output logic [NumInitiators-1:0]                 ReqDataReady,
    output logic [8*DataBusWidth-1:0]                ReqDin,
    output logic [AddressBusWidth-1:0]               MemAddress,
    output logic [8*DataBusWidth-1:0]                MemDout,
    output logic [8*DataBusWidth-1:0]                MemAccess,
    output logic                                     MemWrite,
    input  logic                                     MemReady,
    input  logic                                     MemDataReady,
    input  logic [8*DataBusWidth-1:0]                MemDin,
    output logic                                     Fault
);

    localparam int DataW = 8 * DataBusWidth;
    localparam int IdxW  = (NumInitiators > 1) ? $clog2(NumInitiators) : 1;
    localparam int PtrW  = $clog2(MaxOutstanding);
    localparam int CntW  = PtrW + 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    idx_t prio_q, prio_d;
    ptr_t rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;
    logic fault_q, fault_d;
    idx_t tag_q [MaxOutstanding];
    idx_t tag_d [MaxOutstanding];

    logic [NumInitiators-1:0] requesting, eligible;
    logic fifo_empty, fifo_full, pop_fifo;
    logic win_valid, win_write, accept, bypass, push, spurious;
    idx_t winner;

    // NOTE: every signal written here gets a default before any branch, so no latch can be inferred.
    always_comb begin
        int   scan_idx;
        idx_t scan_i;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == cnt_t'(MaxOutstanding));
        // Read data leaving the FIFO frees a slot this very cycle, so a full FIFO can still take a read.
        pop_fifo   = MemDataReady && !fifo_empty;
        for (int i = 0; i < NumInitiators; i++) begin
            requesting[i] = |ReqAccess[i*DataW +: DataW];
            eligible[i]   = requesting[i] && (ReqWrite[i] || !fifo_full || pop_fifo);
        end

        win_valid = 1'b0;
        winner    = '0;
        scan_idx  = 0;
        scan_i    = '0;
        for (int k = 0; k < NumInitiators; k++) begin
            scan_idx = int'(prio_q) + k;
            if (scan_idx >= NumInitiators) scan_idx = scan_idx - NumInitiators;
            scan_i = idx_t'(scan_idx);
            if (!win_valid && eligible[scan_i]) begin
                win_valid = 1'b1;
                winner    = scan_i;
            end
        end

        accept    = win_valid && MemReady;
        win_write = ReqWrite[winner];
        // A read accepted into an empty FIFO while data is returning goes straight back to its issuer.
        bypass    = accept && !win_write && MemDataReady && fifo_empty;
        push      = accept && !win_write && !bypass;
        spurious  = MemDataReady && fifo_empty && !bypass;
    end

    always_comb begin
        prio_d = prio_q;
        if (accept) prio_d = (winner == idx_t'(NumInitiators - 1)) ? '0 : winner + 1'b1;

        tag_d = tag_q;
        if (push) tag_d[wr_ptr_q] = winner;

        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_fifo);
        count_d  = count_q + cnt_t'(push) - cnt_t'(pop_fifo);
        fault_d  = fault_q | spurious;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            prio_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    // NOTE: tag storage has no reset; entries are only read after being written, gated by count_q.
    always_ff @(posedge Clk) begin
        tag_q <= tag_d;
    end

    always_comb begin
        MemAddress   = '0;
        MemDout      = '0;
        MemAccess    = '0;
        MemWrite     = 1'b0;
        ReqReady     = '0;
        ReqDataReady = '0;
        ReqDin       = '0;
        if (ResetN) begin
            if (win_valid) begin
                MemAddress = ReqAddress[winner*AddressBusWidth +: AddressBusWidth];
                MemDout    = ReqDout[winner*DataW +: DataW];
                MemAccess  = ReqAccess[winner*DataW +: DataW];
                MemWrite   = win_write;
            end
            if (accept) ReqReady[winner] = 1'b1;
            if (pop_fifo)    ReqDataReady[tag_q[rd_ptr_q]] = 1'b1;
            else if (bypass) ReqDataReady[winner] = 1'b1;
            ReqDin = MemDin;
        end
    end

    assign Fault = fault_q;

endmodule

// File: tb/tb_retro_memory_arbiter.sv
// Self-checking bench: a queue-based model of the arbiter checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_retro_memory_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MO = 4;

    logic            Clk = 1'b0;
    logic            ResetN;
    logic [N*AW-1:0] ReqAddress;
    logic [N*DW-1:0] ReqDout, ReqAccess;
    logic [N-1:0]    ReqWrite, ReqReady, ReqDataReady;
    logic [DW-1:0]   ReqDin, MemDout, MemAccess, MemDin;
    logic [AW-1:0]   MemAddress;
    logic            MemWrite, MemReady, MemDataReady, Fault;

    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_dout [N];
    logic [DW-1:0] r_acc  [N];
    logic          r_wr   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ReqAddress[i*AW +: AW] = r_addr[i];
            ReqDout[i*DW +: DW]    = r_dout[i];
            ReqAccess[i*DW +: DW]  = r_acc[i];
            ReqWrite[i]            = r_wr[i];
        end
    end

    always #5 Clk = ~Clk;

    retro_memory_arbiter #(
        .NumInitiators(N), .AddressBusWidth(AW), .DataBusWidth(1), .MaxOutstanding(MO)
    ) dut (
        .Clk(Clk), .ResetN(ResetN),
        .ReqAddress(ReqAddress), .ReqDout(ReqDout), .ReqAccess(ReqAccess), .ReqWrite(ReqWrite),
        .ReqReady(ReqReady), .ReqDataReady(ReqDataReady), .ReqDin(ReqDin),
        .MemAddress(MemAddress), .MemDout(MemDout), .MemAccess(MemAccess), .MemWrite(MemWrite),
        .MemReady(MemReady), .MemDataReady(MemDataReady), .MemDin(MemDin), .Fault(Fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: outstanding read issuers in order, priority pointer, sticky fault.
    int m_tags[$];
    int m_ptr   = 0;
    bit m_fault = 1'b0;
    int n_ptr, n_push;
    bit n_pop, n_fault;
    bit have_nxt = 1'b0;

    initial forever begin
        int win, idx, outstanding;
        bit pop, full, acc, byp;
        logic [N-1:0] exp_rr, exp_dr;
        @(negedge Clk);
        if (!ResetN) begin
            check("rst_req_ready", ReqReady, '0);
            check("rst_data_ready", ReqDataReady, '0);
            check("rst_mem_access", MemAccess, '0);
            check("rst_mem_address", MemAddress, '0);
            check("rst_mem_write", MemWrite, 1'b0);
            check("rst_fault", Fault, 1'b0);
            have_nxt = 1'b0;
        end else begin
            outstanding = m_tags.size();
            full = (outstanding >= MO);
            pop  = MemDataReady && (outstanding > 0);
            win  = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && (r_acc[idx] != '0) && (r_wr[idx] || !full || pop)) win = idx;
            end
            acc = (win >= 0) && MemReady;
            byp = acc && !r_wr[win] && MemDataReady && (outstanding == 0);
            exp_rr = '0;
            if (acc) exp_rr[win] = 1'b1;
            exp_dr = '0;
            if (pop)      exp_dr[m_tags[0]] = 1'b1;
            else if (byp) exp_dr[win] = 1'b1;

            check("model_req_ready", ReqReady, exp_rr);
            check("model_data_ready", ReqDataReady, exp_dr);
            check("model_fault", Fault, m_fault);
            if (win >= 0) begin
                check("model_mem_access", MemAccess, r_acc[win]);
                check("model_mem_address", MemAddress, r_addr[win]);
                check("model_mem_dout", MemDout, r_dout[win]);
                check("model_mem_write", MemWrite, r_wr[win]);
            end else begin
                check("model_mem_idle", MemAccess, '0);
            end
            if (exp_dr != '0) check("model_req_din", ReqDin, MemDin);

            n_pop    = pop;
            n_push   = (acc && !r_wr[win] && !byp) ? win : -1;
            n_ptr    = acc ? (win + 1) % N : m_ptr;
            n_fault  = m_fault | (MemDataReady && (outstanding == 0) && !byp);
            have_nxt = 1'b1;
        end
    end

    initial forever begin
        @(posedge Clk or negedge ResetN);
        if (!ResetN) begin
            m_tags.delete();
            m_ptr    = 0;
            m_fault  = 1'b0;
            have_nxt = 1'b0;
        end else if (have_nxt) begin
            if (n_pop) void'(m_tags.pop_front());
            if (n_push >= 0) m_tags.push_back(n_push);
            m_ptr    = n_ptr;
            m_fault  = n_fault;
            have_nxt = 1'b0;
        end
    end

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0;
            r_dout[i] = '0;
            r_acc[i]  = '0;
            r_wr[i]   = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w);
        r_addr[i] = a;
        r_dout[i] = d;
        r_acc[i]  = 8'hFF;
        r_wr[i]   = w;
    endtask

    task automatic all_read();
        for (int i = 0; i < N; i++) set_req(i, AW'(16'h0100 * i), DW'(8'h40 + i), 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] seq_fill  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [N-1:0] seq_drain [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [N-1:0] seq_rr    [4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0010};
        logic         rdy_rr    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [N-1:0] seq_tail  [3] = '{4'b0010, 4'b1000, 4'b0010};

        ResetN = 1'b0;
        MemReady = 1'b1;
        MemDataReady = 1'b1;
        MemDin = 8'h00;
        all_read();
        @(negedge Clk);
        check("reset_forces_ready", ReqReady, '0);
        check("reset_forces_access", MemAccess, '0);
        check("reset_forces_data_ready", ReqDataReady, '0);
        next_cyc();
        MemDataReady = 1'b0;
        ResetN = 1'b1;

        // Fill: four reads accepted in pointer order, then stall on a full FIFO.
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check($sformatf("fill_ready_%0d", k), ReqReady, seq_fill[k]);
            if (k == 4) check("fill_stall_access", MemAccess, '0);
            next_cyc();
        end
        check("fill_count", m_tags.size(), 4);

        // Two responses; each pop lets one new read in.
        MemDataReady = 1'b1;
        MemDin = 8'hA5;
        @(negedge Clk);
        check("resp0_data_ready", ReqDataReady, 4'b0001);
        check("resp0_din", ReqDin, 8'hA5);
        check("resp0_refill", ReqReady, 4'b0001);
        next_cyc();
        MemDin = 8'h3C;
        @(negedge Clk);
        check("resp1_data_ready", ReqDataReady, 4'b0010);
        check("resp1_din", ReqDin, 8'h3C);
        check("resp1_refill", ReqReady, 4'b0010);
        next_cyc();
        MemDataReady = 1'b0;
        @(negedge Clk);
        check("refull_stall", ReqReady, 4'b0000);
        next_cyc();

        // A write passes a full FIFO and pushes nothing.
        idle_all();
        set_req(2, 16'h1234, 8'h77, 1'b1);
        @(negedge Clk);
        check("write_ready", ReqReady, 4'b0100);
        check("write_flag", MemWrite, 1'b1);
        check("write_address", MemAddress, 16'h1234);
        check("write_data", MemDout, 8'h77);
        next_cyc();
        check("write_no_push", m_tags.size(), 4);

        idle_all();
        MemDataReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            MemDin = DW'(8'h10 + k);
            @(negedge Clk);
            check($sformatf("drain_data_ready_%0d", k), ReqDataReady, seq_drain[k]);
            check($sformatf("drain_din_%0d", k), ReqDin, DW'(8'h10 + k));
            next_cyc();
        end
        MemDataReady = 1'b0;

        // Pointer is now 3; one write from requester 3 brings it back to 0.
        set_req(3, 16'h0000, 8'h00, 1'b1);
        @(negedge Clk);
        check("realign_ready", ReqReady, 4'b1000);
        next_cyc();

        idle_all();
        set_req(1, 16'h1111, 8'h11, 1'b0);
        set_req(3, 16'h3333, 8'h33, 1'b0);
        for (int k = 0; k < 4; k++) begin
            MemReady = rdy_rr[k];
            @(negedge Clk);
            check($sformatf("rr_ready_%0d", k), ReqReady, seq_rr[k]);
            next_cyc();
        end
        MemReady = 1'b1;

        idle_all();
        MemDataReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            MemDin = DW'(8'h60 + k);
            @(negedge Clk);
            check($sformatf("tail_data_ready_%0d", k), ReqDataReady, seq_tail[k]);
            next_cyc();
        end

        // Static memory: accept and return in the same cycle through the empty bypass.
        set_req(0, 16'h0042, 8'h00, 1'b0);
        MemDin = 8'h5A;
        @(negedge Clk);
        check("static_ready", ReqReady, 4'b0001);
        check("static_data_ready", ReqDataReady, 4'b0001);
        check("static_din", ReqDin, 8'h5A);
        next_cyc();
        idle_all();
        MemDataReady = 1'b0;
        check("static_fifo_empty", m_tags.size(), 0);
        @(negedge Clk);
        check("static_no_fault", Fault, 1'b0);
        next_cyc();

        MemDataReady = 1'b1;
        @(negedge Clk);
        check("spurious_no_data_ready", ReqDataReady, '0);
        next_cyc();
        MemDataReady = 1'b0;
        @(negedge Clk);
        check("spurious_fault", Fault, 1'b1);
        next_cyc();

        // Reset in the middle of traffic clears everything immediately.
        all_read();
        next_cyc();
        next_cyc();
        @(posedge Clk);
        #3;
        ResetN = 1'b0;
        #1;
        check("midreset_fault", Fault, 1'b0);
        check("midreset_ready", ReqReady, '0);
        check("midreset_access", MemAccess, '0);
        next_cyc();
        ResetN = 1'b1;
        @(negedge Clk);
        check("after_reset_pointer", ReqReady, 4'b0001);
        next_cyc();
        next_cyc();
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
